// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default timing constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_WIDTH   = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous clear and bit_done pulse
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter draining a synchronous byte FIFO onto the tx line
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_valid,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [BW-1:0]         bit_idx;
  logic                  bit_done;
  logic                  baud_clear;

  // Holding the counter clear in IDLE/FETCH makes the start bit begin at count 0.
  assign baud_clear = (state == IDLE) || (state == FETCH);
  assign fifo_rd_en = (state == IDLE) && !fifo_empty && !rst;
  assign shifted    = shift_reg >> 1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= !fifo_empty;
          if (!fifo_empty) state <= FETCH;
        end
        FETCH: begin
          busy <= 1'b1;
          if (fifo_valid) begin
            shift_reg <= fifo_dout;
            bit_idx   <= '0;
            tx        <= 1'b0;
            state     <= START;
          end else begin
            tx    <= 1'b1;
            state <= IDLE;
          end
        end
        START: begin
          busy <= 1'b1;
          if (bit_done) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          busy <= 1'b1;
          if (bit_done) begin
            shift_reg <= shifted;
            if (bit_idx == BW'(DATA_WIDTH - 1)) begin
              tx      <= 1'b1;
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              tx      <= shifted[0];
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        STOP: begin
          // busy stays high into the first IDLE cycle, one cycle behind the state.
          busy <= 1'b1;
          tx   <= 1'b1;
          if (bit_done) begin
            if (bit_idx == BW'(STOP_BITS - 1)) begin
              state <= IDLE;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx with CLKS_PER_BIT=4
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dout_a = '0, dout_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       empty_a = 1'b1, empty_b = 1'b1;
  logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b;
  logic       suppress = 1'b0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] pa, pb;

  logic tx_log   [2][256];
  logic busy_log [2][256];
  logic rd_log   [2][256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .fifo_dout(dout_a), .fifo_valid(valid_a),
    .fifo_empty(empty_a), .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .fifo_dout(dout_b), .fifo_valid(valid_b),
    .fifo_empty(empty_b), .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b)
  );

  // FIFO models: registered dout/valid and empty flag, one cycle after the edge.
  always @(posedge clk) begin
    if (rd_a && qa.size() > 0) begin
      pa = qa.pop_front();
      dout_a  <= pa;
      valid_a <= !suppress;
    end else begin
      valid_a <= 1'b0;
    end
    empty_a <= (qa.size() == 0);
    if (rd_b && qb.size() > 0) begin
      pb = qb.pop_front();
      dout_b  <= pb;
      valid_b <= 1'b1;
    end else begin
      valid_b <= 1'b0;
    end
    empty_b <= (qb.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[0][i] = tx_a;   busy_log[0][i] = busy_a; rd_log[0][i] = rd_a;
      tx_log[1][i] = tx_b;   busy_log[1][i] = busy_b; rd_log[1][i] = rd_b;
      @(negedge clk);
    end
  endtask

  function automatic logic get_sig(int d, int sig, int i);
    case (sig)
      0:       return tx_log[d][i];
      1:       return busy_log[d][i];
      default: return rd_log[d][i];
    endcase
  endfunction

  function automatic int count_val(int d, int sig, int n, logic v);
    int c = 0;
    for (int i = 0; i < n; i++) if (get_sig(d, sig, i) === v) c++;
    return c;
  endfunction

  function automatic int first_idx(int d, int sig, int from, int n, logic v);
    for (int i = from; i < n; i++) if (get_sig(d, sig, i) === v) return i;
    return -1;
  endfunction

  // Independent frame model: start, LSB-first data, stop bits, 4 clocks each.
  function automatic int frame_errs(int d, int s, logic [7:0] b, int stop_bits);
    int   errs = 0;
    int   bitn;
    logic e;
    if (s < 0) return 999;
    for (int k = 0; k < (9 + stop_bits) * 4; k++) begin
      bitn = k / 4;
      if (bitn == 0)      e = 1'b0;
      else if (bitn <= 8) e = b[bitn-1];
      else                e = 1'b1;
      if (s + k > 255 || tx_log[d][s+k] !== e) errs++;
    end
    return errs;
  endfunction

  initial begin
    int s, r1, r2;
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r1, r2;

    repeat (3) @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_rd_en", rd_a, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0x55
    qa.push_back(8'h55);
    @(negedge clk);
    capture(60);
    check("t1_rd_count", count_val(0, 2, 60, 1'b1), 1);
    check("t1_rd_pos", first_idx(0, 2, 0, 60, 1'b1), 0);
    s = first_idx(0, 0, 0, 60, 1'b0);
    check("t1_start", s, 2);
    check("t1_frame", frame_errs(0, s, 8'h55, 1), 0);
    check("t1_busy_count", count_val(0, 1, 60, 1'b1), 42);
    check("t1_busy_fetch", busy_log[0][1], 1);
    check("t1_busy_lag", busy_log[0][42], 1);
    check("t1_busy_done", busy_log[0][43], 0);
    check("t1_tx_after", tx_log[0][42], 1);

    // Back-to-back 0xA5, 0x3C
    qa.push_back(8'hA5);
    qa.push_back(8'h3C);
    @(negedge clk);
    capture(100);
    check("t2_rd_count", count_val(0, 2, 100, 1'b1), 2);
    r1 = first_idx(0, 2, 0, 100, 1'b1);
    r2 = first_idx(0, 2, r1 + 1, 100, 1'b1);
    check("t2_rd_first", r1, 0);
    check("t2_rd_gap", r2 - r1, 42);
    check("t2_frame1", frame_errs(0, 2, 8'hA5, 1), 0);
    check("t2_gap0", tx_log[0][42], 1);
    check("t2_gap1", tx_log[0][43], 1);
    s = first_idx(0, 0, 42, 100, 1'b0);
    check("t2_start2", s, 44);
    check("t2_frame2", frame_errs(0, s, 8'h3C, 1), 0);

    // Empty FIFO: no activity
    capture(100);
    check("t3_rd_count", count_val(0, 2, 100, 1'b1), 0);
    check("t3_tx_low", count_val(0, 0, 100, 1'b0), 0);
    check("t3_busy", count_val(0, 1, 100, 1'b1), 0);

    // FETCH without valid data, then a normal frame
    suppress = 1'b1;
    qa.push_back(8'h81);
    @(negedge clk);
    capture(20);
    suppress = 1'b0;
    check("t4_rd_count", count_val(0, 2, 20, 1'b1), 1);
    check("t4_tx_low", count_val(0, 0, 20, 1'b0), 0);
    check("t4_busy_end", busy_log[0][19], 0);
    qa.push_back(8'h0F);
    @(negedge clk);
    capture(50);
    check("t4_start", first_idx(0, 0, 0, 50, 1'b0), 2);
    check("t4_frame", frame_errs(0, 2, 8'h0F, 1), 0);

    // Reset in the middle of data bit 3 of 0xFF
    qa.push_back(8'hFF);
    @(negedge clk);
    repeat (19) @(negedge clk);
    check("t5_pre_busy", busy_a, 1);
    check("t5_pre_tx", tx_a, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_tx", tx_a, 1);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_rd", rd_a, 0);
    rst = 1'b0;
    capture(60);
    check("t5_rd_after", count_val(0, 2, 60, 1'b1), 0);
    check("t5_tx_after", count_val(0, 0, 60, 1'b0), 0);
    check("t5_busy_after", count_val(0, 1, 60, 1'b1), 0);

    // Two stop bits, byte 0x00
    qb.push_back(8'h00);
    @(negedge clk);
    capture(60);
    s = first_idx(1, 0, 0, 60, 1'b0);
    check("t6_start", s, 2);
    check("t6_frame", frame_errs(1, s, 8'h00, 2), 0);
    check("t6_low_run", count_val(1, 0, 60, 1'b0), 36);
    check("t6_busy_count", count_val(1, 1, 60, 1'b1), 46);
    check("t6_tx_after", tx_log[1][46], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that drains the synchronous byte FIFO directly downstream of it and serialises each byte onto the tx line.
- Frame format is 8N1 by default, with a configurable stop-bit count.
- Pops one entry at a time using the FIFO's rd_en/valid protocol: dout and valid are registered one cycle after rd_en.
- Sits between the TX FIFO and the board-level UART TX pin.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the FIFO DATA_WIDTH.
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200 baud); minimum legal value 2.
- STOP_BITS, 1, number of stop bit periods; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active high.
- fifo_dout  input  DATA_WIDTH  FIFO read data; meaningful only when fifo_valid=1.
- fifo_valid  input  1  FIFO read-data-valid; high the cycle after an accepted rd_en.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop request.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous, active high. On reset:
  - state=IDLE, tx=1, busy=0, fifo_rd_en=0.
  - Baud counter, bit index and shift register all cleared.
- States are IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - tx=1.
  - fifo_rd_en = (state==IDLE) && !fifo_empty. This is combinational and is the only place rd_en can be high.
  - If !fifo_empty: go to FETCH at the next edge. Exactly one rd_en cycle is issued per frame.
- FETCH (one cycle):
  - If fifo_valid=1: latch fifo_dout into shift_reg, clear baud_cnt, go to START.
  - If fifo_valid=0 (FIFO reset or underflow race): return to IDLE. No frame is sent and tx stays 1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx=shift_reg[0], sent LSB first.
  - At the end of each bit period, shift right by one and increment bit_idx.
  - After DATA_WIDTH bits, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT).
  - The bit period ends on the cycle baud_cnt==CLKS_PER_BIT-1; the counter wraps to 0 there.
  - Reloaded to 0 on every state change.
- bit_idx width is $clog2(DATA_WIDTH)+1, so it never wraps before DATA_WIDTH.
- tx is a registered output, so the line is glitch-free.
- Frame length is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames:
  - Stop period ends, then 1 IDLE cycle (rd_en asserted), then 1 FETCH cycle, then the start bit.
  - This gives an inter-frame gap of exactly 2 extra clk cycles of tx=1 between frames.
- fifo_empty is ignored outside IDLE. Bytes written mid-frame wait for the next IDLE.
- Reset mid-frame:
  - tx=1 on the cycle after the reset edge and the frame is truncated.
  - No rd_en is issued while rst=1.
- fifo_dout is never sampled outside FETCH.

Decomposition:
- Shared package/header uart_pkg:
  - State encoding localparams (IDLE=0, FETCH=1, START=2, DATA=3, STOP=4; 3 bits).
  - Default CLKS_PER_BIT and DATA_WIDTH constants, shared with the future uart_rx.
- One natural sub-module, uart_baud_gen:
  - Cycle counter with a synchronous clear input and a one-cycle bit_done pulse output.
  - Parameterised by CLKS_PER_BIT.
  - Reused by uart_rx at half-bit offset.
- FSM and shift register stay in uart_tx.

Test Plan:
- Single byte: CLKS_PER_BIT=4, FIFO holds 0x55, then empty.
  - Required: exactly one rd_en pulse.
  - tx = 0 (start), 1,0,1,0,1,0,1,0 (LSB first), 1 (stop), each held 4 cycles; frame = 40 cycles.
  - busy high for 42 cycles in total: FETCH (1 cycle) + frame (40) + the 1-cycle IDLE lag from the registered state.
- Back-to-back: FIFO holds 0xA5, 0x3C.
  - Required: two rd_en pulses 42 cycles apart.
  - Second start bit begins exactly 2 cycles after the first stop bit ends.
  - Bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Empty FIFO for 100 cycles: fifo_rd_en never asserted, tx=1 throughout, busy=0 throughout.
- FETCH with fifo_valid forced 0: state returns to IDLE, tx stays 1, no start bit. Next non-empty gives a normal frame.
- Reset pulse during DATA bit 3 of 0xFF: tx=1 and busy=0 on the next cycle. After release with an empty FIFO, no further activity.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0x00: stop high for 8 cycles, frame = 44 cycles.
